// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the exhaustive 4-bit adder BIST checker.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int VEC_W       = 4;
  localparam int NUM_VECTORS = 256;
  localparam int ERR_W       = 9;
  localparam int SETTLE_W    = 4;

  // Sum of two operands with the carry-out dropped.
  function automatic logic [VEC_W-1:0] add_mod(input logic [VEC_W-1:0] x,
                                               input logic [VEC_W-1:0] y);
    logic [VEC_W:0] full;
    full = {1'b0, x} + {1'b0, y};
    return full[VEC_W-1:0];
  endfunction

endpackage

// File: rtl/adder_bist_ref_model.sv
// Golden reference for the adder under test: purely combinational (a+b) mod 16.
module adder_bist_ref_model
  import adder_bist_pkg::*;
(
  input  logic [VEC_W-1:0] a,
  input  logic [VEC_W-1:0] b,
  output logic [VEC_W-1:0] expected
);

  // Expected sum for the operands currently applied to the adder.
  always_comb begin
    expected = add_mod(a, b);
  end

endmodule

// File: rtl/adder_bist_checker.sv
// Exhaustive BIST sequencer for a 4-bit adder: walks all 256 operand pairs
// (b inner, a outer), waits SETTLE_CYCLES per vector, then compares the
// returned sum against the reference model in one CHECK cycle.
// Optional build macro ADDER_BIST_STOP_ON_FAIL_EN: stop the run at the first
// mismatching vector, leaving a/b frozen on it.
module adder_bist_checker
  import adder_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [VEC_W-1:0] dut_sum,
  output logic [VEC_W-1:0] a,
  output logic [VEC_W-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] fail_a,
  output logic [VEC_W-1:0] fail_b
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0]    ERR_MAX     = {ERR_W{1'b1}};
  localparam logic [VEC_W-1:0]    VEC_MAX     = {VEC_W{1'b1}};

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [VEC_W-1:0]    expected;
  logic                mismatch;
  logic                first_fail;
  logic                last_vector;
  logic                finish_run;
  logic [ERR_W-1:0]    err_next;

  adder_bist_ref_model u_ref_model (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  // Compare result and next error count, evaluated for use in CHECK.
  always_comb begin
    mismatch    = (dut_sum != expected);
    first_fail  = mismatch && (err_count == {ERR_W{1'b0}});
    last_vector = (a == VEC_MAX) && (b == VEC_MAX);
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + ERR_W'(1);
    end else begin
      err_next = err_count;
    end
`ifdef ADDER_BIST_STOP_ON_FAIL_EN
    finish_run = last_vector || mismatch;
`else
    finish_run = last_vector;
`endif
  end

  // Run sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= {SETTLE_W{1'b0}};
      a          <= {VEC_W{1'b0}};
      b          <= {VEC_W{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= {ERR_W{1'b0}};
      fail_a     <= {VEC_W{1'b0}};
      fail_b     <= {VEC_W{1'b0}};
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= DRIVE;
            settle_cnt <= {SETTLE_W{1'b0}};
            a          <= {VEC_W{1'b0}};
            b          <= {VEC_W{1'b0}};
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= {ERR_W{1'b0}};
            fail_a     <= {VEC_W{1'b0}};
            fail_b     <= {VEC_W{1'b0}};
          end else begin
            state <= state;
          end
        end
        DRIVE: begin
          // Operands stay put while the adder output settles.
          if (settle_cnt == SETTLE_LAST) begin
            state      <= CHECK;
            settle_cnt <= {SETTLE_W{1'b0}};
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end
        CHECK: begin
          err_count <= err_next;
          if (first_fail) begin
            fail_a <= a;
            fail_b <= b;
          end else begin
            fail_a <= fail_a;
          end
          if (finish_run) begin
            // a/b are left on the last checked vector.
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == {ERR_W{1'b0}});
          end else begin
            state  <= DRIVE;
            {a, b} <= {a, b} + (2 * VEC_W)'(1);
          end
        end
        default: begin
          state      <= IDLE;
          settle_cnt <= {SETTLE_W{1'b0}};
          busy       <= 1'b0;
          done       <= 1'b0;
          pass       <= 1'b0;
        end
      endcase
    end
  end

endmodule
